// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch controller and its decoder.
package ifetch_pkg;

    // Opcodes (inst[31:26]) that redirect the program counter.
    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;

    // Word substituted when a fetch is abandoned (timeout or misaligned PC).
    localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

    // Cycles imem_req may stay high without an ack.
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        STEP = 2'd3
    } state_e;

endpackage

// File: rtl/ifetch_decode.sv
// Combinational next-PC decode: jump/branch selects plus offset and target
// fields. Also used by the decode stage.
module ifetch_decode
    import ifetch_pkg::*;
(
    input  logic [31:0] inst,
    input  logic        br_eq,
    output logic        pc_jmp,
    output logic        pc_br,
    output logic [15:0] pc_off,
    output logic [25:0] pc_tgt
);

    // Select jump or branch from the opcode; jump wins, so both are never 1.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would infer a latch.
        pc_jmp = 1'b0;
        pc_br  = 1'b0;
        pc_off = inst[15:0];
        pc_tgt = inst[25:0];
        case (inst[31:26])
            OP_J, OP_JAL: pc_jmp = 1'b1;
            OP_BEQ:       pc_br  = br_eq;
            OP_BNE:       pc_br  = ~br_eq;
            default:      ;
        endcase
    end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: reads one word per PC value over a req/ack
// memory handshake, offers it downstream with valid/ready, then strobes
// pc_step once with the decoded next-PC selects.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int          TIMEOUT  = TIMEOUT_DEF,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_val,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        br_eq,
    output logic        pc_step,
    output logic        pc_jmp,
    output logic        pc_br,
    output logic [15:0] pc_off,
    output logic [25:0] pc_tgt,
    output logic        fetch_err
);

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   inst_q, inst_d;
    logic          err_q, err_d;
    logic          jmp_q, jmp_d;
    logic          br_q, br_d;

    logic          dec_jmp, dec_br;
    logic          misaligned;

    assign misaligned = (pc_val[1:0] != 2'b00);

    ifetch_decode u_decode (
        .inst   (inst_q),
        .br_eq  (br_eq),
        .pc_jmp (dec_jmp),
        .pc_br  (dec_br),
        .pc_off (pc_off),
        .pc_tgt (pc_tgt)
    );

    // Next-state logic: fetch, hold for the consumer, then one PC step.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;          // wait counter is zero on every entry to REQ
        inst_d  = inst_q;
        err_d   = err_q;
        jmp_d   = 1'b0;        // selects live only for the STEP cycle
        br_d    = 1'b0;
        case (state_q)
            IDLE: state_d = REQ;  // let the PC settle on its reset vector
            REQ: begin
                if (misaligned) begin
                    inst_d  = NOP_WORD;
                    err_d   = 1'b1;
                    state_d = HOLD;
                end else if (imem_ack) begin
                    inst_d  = imem_rdata;
                    state_d = HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    inst_d  = NOP_WORD;
                    err_d   = 1'b1;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                if (inst_ready) begin
                    // br_eq is only meaningful at the handshake edge.
                    jmp_d   = dec_jmp;
                    br_d    = dec_br;
                    state_d = STEP;
                end
            end
            STEP:    state_d = REQ;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any outstanding request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            inst_q  <= '0;
            err_q   <= 1'b0;
            jmp_q   <= 1'b0;
            br_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
            jmp_q   <= jmp_d;
            br_q    <= br_d;
        end
    end

    assign imem_req   = (state_q == REQ) && !misaligned;
    assign imem_addr  = (state_q == REQ) ? pc_val : 32'h0;
    assign inst       = inst_q;
    assign inst_valid = (state_q == HOLD);
    assign pc_step    = (state_q == STEP);
    assign pc_jmp     = jmp_q;
    assign pc_br      = br_q;
    assign fetch_err  = err_q;

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
- Reader side of the program counter. Samples `pc_val`, fetches the instruction word from instruction memory over a req/ack handshake, and presents it downstream with a valid/ready handshake.
- Decodes J/JAL/BEQ/BNE and drives `pc_jmp`/`pc_br`/`pc_off`/`pc_tgt` back to the PC together with a one-cycle `pc_step` strobe.
- The PC register updates only on `pc_step`, so exactly one PC update occurs per fetched instruction.

Parameters:
- TIMEOUT, 16: max cycles `imem_req` is held without `imem_ack` before the fetch is abandoned.
- NOP_WORD, 32'h00000000: instruction substituted on a fetch error.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- pc_val  in  32  current PC value.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  32  fetch address.
- imem_ack  in  1  memory ack; data valid the same cycle.
- imem_rdata  in  32  fetched word.
- inst  out  32  instruction to decode stage.
- inst_valid  out  1  `inst` valid.
- inst_ready  in  1  decode stage accepts `inst`.
- br_eq  in  1  rs==rt compare result for the held `inst`; valid while `inst_valid`=1.
- pc_step  out  1  one-cycle strobe: PC must update this edge.
- pc_jmp  out  1  jump select, qualified by `pc_step`.
- pc_br  out  1  branch-taken select, qualified by `pc_step`.
- pc_off  out  16  branch offset (inst[15:0]).
- pc_tgt  out  26  jump target (inst[25:0]).
- fetch_err  out  1  sticky: timeout or misaligned PC seen.

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst` is asynchronous and active-low.
- Reset values: state=IDLE. `imem_req`, `inst_valid`, `pc_step`, `pc_jmp`, `pc_br`, `fetch_err` all 0. `inst`, `imem_addr`, `pc_off`, `pc_tgt` all 0.
- A reset assertion in any state, including mid-request, returns to IDLE immediately and drops `imem_req`. Memory must tolerate an abandoned request.
- States and transitions:
  - IDLE: wait one cycle -> REQ. Gives the PC time to present its reset vector.
  - REQ: `imem_req`=1 and `imem_addr`=`pc_val`, both held stable.
    - If `pc_val[1:0]`!=0: no request is issued; `inst`<=NOP_WORD, `fetch_err`<=1 -> HOLD.
    - On `imem_ack` at a rising edge: `inst`<=`imem_rdata` -> HOLD. Zero wait states is legal: ack may arrive in the first REQ cycle.
    - Wait counter counts REQ cycles. When TIMEOUT is reached without ack: `inst`<=NOP_WORD, `fetch_err`<=1 -> HOLD.
    - The counter clears on entry to REQ.
  - HOLD: `inst_valid`=1 and `inst` stable until `inst_ready`=1 (backpressure is unbounded). On handshake -> STEP, registering the decode results.
  - STEP: `pc_step`=1 for exactly one cycle with the registered selects -> REQ. The new `pc_val` is visible in the following REQ cycle.
- Decode, using opcode = inst[31:26]:
  - 02 (J) / 03 (JAL): `pc_jmp`=1.
  - 04 (BEQ): `pc_br`=`br_eq`.
  - 05 (BNE): `pc_br`=!`br_eq`.
  - Any other opcode: both selects 0.
  - `pc_jmp` has priority; `pc_jmp` and `pc_br` are never both 1.
  - `pc_off`=inst[15:0] and `pc_tgt`=inst[25:0] always.
  - `br_eq` is sampled on the `inst_ready` handshake edge.
- Outside STEP, `pc_jmp`, `pc_br` and `pc_step` are 0.
- Steady-state throughput: 1 instruction per 3 cycles plus memory wait plus backpressure.
- `fetch_err` clears only on reset.

Decomposition:
- Shared package (`ifetch_pkg`): opcode constants OP_J, OP_JAL, OP_BEQ, OP_BNE; state encoding IDLE/REQ/HOLD/STEP; NOP_WORD default.
- Combinational sub-module `ifetch_decode`: inputs `inst` and `br_eq`; outputs `pc_jmp`, `pc_br`, `pc_off`, `pc_tgt`. Reused later by the decode stage.

Test Plan:
- Reset release, PC=0xbfc00000, memory acks after 2 cycles with 0x24080001 -> `imem_addr`=0xbfc00000; `inst_valid` with `inst`=0x24080001; one `pc_step` with `pc_jmp`=`pc_br`=0; next fetch address 0xbfc00004.
- Fetch 0x08000010 (J) -> at `pc_step`: `pc_jmp`=1, `pc_tgt`=0x0000010; next `imem_addr`=0xb0000040.
- Fetch 0x1000FFFF (BEQ): with `br_eq`=1 -> `pc_br`=1, `pc_off`=0xFFFF; repeat with `br_eq`=0 -> `pc_br`=0. BNE 0x14000002 with `br_eq`=0 -> `pc_br`=1.
- Ack never arrives -> `imem_req` high for exactly 16 cycles, then `inst`=0 and `fetch_err`=1; `pc_step` with no jump or branch.
- `inst_ready` held low 10 cycles -> `inst` stable, `inst_valid`=1, no `pc_step` until ready; a misaligned `pc_val`=0x...2 -> no `imem_req`, NOP, `fetch_err`=1.
- `rst` asserted while in REQ mid-wait -> `imem_req` drops asynchronously; after release, one IDLE cycle then a fresh request at the reset vector.
